regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file with a per-register pending-write scoreboard, for the dual-writeback core pipeline. It provides two read ports and two write ports, with optional write-to-read bypass. Issue logic marks a destination register as pending, and writeback clears the mark, so decode can stall on RAW hazards. Register 0 is hardwired to zero.

Parameters:
XLEN, 32, data width of each register
AW, 5, address width; the array holds NREG = 2**AW entries
BYPASS, 1, 1 = same-cycle writeback data is forwarded to the read ports and busy outputs; 0 = no forwarding

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
wr0_en  input  1  write port 0 enable
wr0_addr  input  AW  write port 0 address
wr0_data  input  XLEN  write port 0 data
wr1_en  input  1  write port 1 enable; higher priority than port 0
wr1_addr  input  AW  write port 1 address
wr1_data  input  XLEN  write port 1 data
rd_addr_a  input  AW  read port A address
rd_data_a  output  XLEN  read port A data (combinational)
busy_a  output  1  register at rd_addr_a has a pending write
rd_addr_b  input  AW  read port B address
rd_data_b  output  XLEN  read port B data (combinational)
busy_b  output  1  register at rd_addr_b has a pending write
iss_en  input  1  issue: mark iss_rd pending
iss_rd  input  AW  destination register of the issued instruction
pend_cnt  output  AW+1  number of registers currently pending (registered)

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - All NREG entries clear to 0, including the highest index.
  - All busy bits clear, pend_cnt = 0.
  - Reset overrides any simultaneous write or issue.
- Register 0:
  - Writes to address 0 are discarded, and issue to address 0 is ignored.
  - Reads of address 0 return 0; busy_a/busy_b are 0 for address 0 regardless of BYPASS.
- Writes:
  - A write commits on the rising edge when enabled and the address is nonzero.
  - If wr0_addr == wr1_addr with both enabled, port 1 data is stored.
- Reads with BYPASS=0: rd_data_x = array[rd_addr_x]; same-cycle writes are visible only from the next cycle.
- Reads with BYPASS=1: priority order for rd_data_x is
  1. wr1 active to the same nonzero address → wr1_data
  2. else wr0 active to that address → wr0_data
  3. else array[rd_addr_x]
- Scoreboard, per register r (nonzero):
  - next busy[r] = (iss_en & iss_rd==r) | (busy[r] & ~clr[r]).
  - clr[r] = (wr0_en & wr0_addr==r) | (wr1_en & wr1_addr==r).
  - Simultaneous issue and writeback to the same r: set wins; busy stays 1 for the new producer.
  - A writeback to a non-busy register is legal: data is written and the busy bit is unchanged.
- busy_x:
  - BYPASS=0: busy_x = busy[rd_addr_x].
  - BYPASS=1: busy_x = busy[rd_addr_x] & ~clr[rd_addr_x], so a same-cycle writeback releases the stall.
  - An issue in the current cycle is not visible on busy_x until the next cycle.
- pend_cnt:
  - Registered population count of busy[], updated every cycle from next-state busy.
  - Range 0..NREG-1.
- Latency:
  - Write-to-read: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
  - Issue-to-busy: 1 cycle.
- Reads and busy outputs are fully combinational from the address inputs and current state; no handshake.

Test Plan:
- Reset then read all 32 addresses → every rd_data = 0, busy = 0, pend_cnt = 0. Checks that the highest entry (31) is also cleared.
- Write 0xDEADBEEF to x0 and 0x12345678 to x31 → x0 reads 0, x31 reads 0x12345678 next cycle.
- Both ports write x5 in the same cycle (wr0=0x1, wr1=0x2) → x5 = 0x2. With BYPASS=1, rd_addr_a=5 that same cycle returns 0x2.
- iss_en x7 at cycle N → busy_a (rd_addr_a=7) = 1 at N+1 and pend_cnt = 1. wr0 to x7 at N+3 → with BYPASS=1, busy_a = 0 and rd_data_a = new data in N+3; pend_cnt = 0 at N+4.
- Issue x9 and writeback x9 in the same cycle while x9 is busy → busy stays 1 and pend_cnt is unchanged.
- Issue x3 and x4, then assert reset together with wr1 to x3 → next cycle all busy = 0, pend_cnt = 0, x3 = 0.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
// Multi-port integer register file with a per-register pending-write
// scoreboard for the dual-writeback pipeline.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   wr0_en/addr/data        write port 0
//   wr1_en/addr/data        write port 1 (wins over port 0 on same address)
//   rd_addr_a, rd_data_a    combinational read port A
//   busy_a                  register at rd_addr_a has a pending write
//   rd_addr_b, rd_data_b    combinational read port B
//   busy_b                  register at rd_addr_b has a pending write
//   iss_en, iss_rd          issue: mark iss_rd pending from the next cycle
//   pend_cnt                registered count of pending registers
//
// Register 0 reads as zero, ignores writes and is never marked pending.
// BYPASS=1 forwards same-cycle writeback data (and its busy release) to
// the read ports.
module regfile_mp_sb #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr0_en,
  input  logic [AW-1:0]   wr0_addr,
  input  logic [XLEN-1:0] wr0_data,
  input  logic            wr1_en,
  input  logic [AW-1:0]   wr1_addr,
  input  logic [XLEN-1:0] wr1_data,
  input  logic [AW-1:0]   rd_addr_a,
  output logic [XLEN-1:0] rd_data_a,
  output logic            busy_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] rd_data_b,
  output logic            busy_b,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic [AW:0]     pend_cnt
);

  localparam int NREG = 2 ** AW;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + (AW+1)'(v[i]);
    end
    return c;
  endfunction

  // Read mux: port 1 forwarding beats port 0, which beats the array.
  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   addr,
    input logic [XLEN-1:0] arr_val,
    input logic            w0_en,
    input logic [AW-1:0]   w0_addr,
    input logic [XLEN-1:0] w0_data,
    input logic            w1_en,
    input logic [AW-1:0]   w1_addr,
    input logic [XLEN-1:0] w1_data
  );
    logic [XLEN-1:0] r;
    r = arr_val;
    if (BYPASS != 0) begin
      if (w1_en && (w1_addr == addr)) begin
        r = w1_data;
      end else if (w0_en && (w0_addr == addr)) begin
        r = w0_data;
      end
    end
    if (addr == '0) begin
      r = '0;
    end
    return r;
  endfunction

  // Scoreboard next state. Bit 0 is forced clear so x0 never reports busy.
  always_comb begin
    clr = '0;
    set = '0;
    if (wr0_en) clr[wr0_addr] = 1'b1;
    if (wr1_en) clr[wr1_addr] = 1'b1;
    if (iss_en) set[iss_rd]   = 1'b1;
    clr[0] = 1'b0;
    set[0] = 1'b0;
    // A same-cycle issue re-arms the bit for the new producer.
    busy_nxt = set | (busy & ~clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= popcount(busy_nxt);
    end
  end

  // Port 1 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr0_en && (wr0_addr != '0)) regs[wr0_addr] <= wr0_data;
      if (wr1_en && (wr1_addr != '0)) regs[wr1_addr] <= wr1_data;
    end
  end

  always_comb begin
    rd_data_a = read_port(rd_addr_a, regs[rd_addr_a], wr0_en, wr0_addr,
                          wr0_data, wr1_en, wr1_addr, wr1_data);
    rd_data_b = read_port(rd_addr_b, regs[rd_addr_b], wr0_en, wr0_addr,
                          wr0_data, wr1_en, wr1_addr, wr1_data);
    // With forwarding, a same-cycle writeback releases the stall at once.
    if (BYPASS != 0) begin
      busy_a = busy[rd_addr_a] & ~clr[rd_addr_a];
      busy_b = busy[rd_addr_b] & ~clr[rd_addr_b];
    end else begin
      busy_a = busy[rd_addr_a];
      busy_b = busy[rd_addr_b];
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb
// Self-checking bench for regfile_mp_sb (XLEN=32, AW=5, BYPASS=1) against a
// behavioural model made of a value array and a pending flag per register.
module tb_regfile_mp_sb;

  logic        clk;
  logic        reset;
  logic        wr0_en, wr1_en, iss_en;
  logic [4:0]  wr0_addr, wr1_addr, rd_addr_a, rd_addr_b, iss_rd;
  logic [31:0] wr0_data, wr1_data, rd_data_a, rd_data_b;
  logic        busy_a, busy_b;
  logic [5:0]  pend_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_reg  [32];
  bit          m_busy [32];

  regfile_mp_sb #(.XLEN(32), .AW(5), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .busy_a(busy_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .busy_b(busy_b),
    .iss_en(iss_en), .iss_rd(iss_rd), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [5:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return 6'(n);
  endfunction

  task automatic idle();
    reset = 0; wr0_en = 0; wr1_en = 0; iss_en = 0;
    wr0_addr = 0; wr1_addr = 0; iss_rd = 0;
    wr0_data = 0; wr1_data = 0;
  endtask

  // One rising edge; the model takes the same inputs the DUT sees.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i] = 0;
        m_busy[i] = 0;
      end
    end else begin
      if (wr0_en && wr0_addr != 0) begin
        m_reg[wr0_addr] = wr0_data;
        m_busy[wr0_addr] = 0;
      end
      if (wr1_en && wr1_addr != 0) begin
        m_reg[wr1_addr] = wr1_data;
        m_busy[wr1_addr] = 0;
      end
      if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    // Dirty the top entry first so its clearing is observable.
    idle();
    wr1_en = 1; wr1_addr = 31; wr1_data = 32'hFFFF_FFFF;
    iss_en = 1; iss_rd = 31;
    step();
    idle(); reset = 1;
    step();
    idle();
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = 5'(a); rd_addr_b = 5'(31 - a);
      #1;
      checks++;
      if (rd_data_a !== 32'h0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_a addr=%0d data=%h busy=%b required data=0 busy=0", a, rd_data_a, busy_a);
      end
      checks++;
      if (rd_data_b !== 32'h0 || busy_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_b addr=%0d data=%h busy=%b required data=0 busy=0", 31 - a, rd_data_b, busy_b);
      end
    end
    checks++;
    if (pend_cnt !== 6'd0) begin
      errors++;
      $display("FAIL reset_pend_cnt got %0d required 0", pend_cnt);
    end
  endtask

  task automatic test_x0_x31();
    idle();
    wr0_en = 1; wr0_addr = 0;  wr0_data = 32'hDEAD_BEEF;
    wr1_en = 1; wr1_addr = 31; wr1_data = 32'h1234_5678;
    step();
    idle(); rd_addr_a = 0; rd_addr_b = 31;
    #1;
    checks++;
    if (rd_data_a !== 32'h0) begin
      errors++;
      $display("FAIL x0_read got %h required 0", rd_data_a);
    end
    checks++;
    if (rd_data_b !== 32'h1234_5678) begin
      errors++;
      $display("FAIL x31_read got %h required 12345678", rd_data_b);
    end
  endtask

  task automatic test_same_addr();
    idle();
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'h1;
    wr1_en = 1; wr1_addr = 5; wr1_data = 32'h2;
    rd_addr_a = 5;
    #1;
    checks++;
    if (rd_data_a !== 32'h2) begin
      errors++;
      $display("FAIL same_addr_bypass got %h required 2", rd_data_a);
    end
    step();
    idle();
    #1;
    checks++;
    if (rd_data_a !== 32'h2) begin
      errors++;
      $display("FAIL same_addr_stored got %h required 2", rd_data_a);
    end
  endtask

  task automatic test_issue_wb();
    idle();
    iss_en = 1; iss_rd = 7; rd_addr_a = 7;
    #1;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL issue_same_cycle busy got %b required 0", busy_a);
    end
    step();                       // now cycle N+1
    idle();
    #1;
    checks++;
    if (busy_a !== 1'b1 || pend_cnt !== 6'd1) begin
      errors++;
      $display("FAIL issue_n1 busy=%b pend=%0d required busy=1 pend=1", busy_a, pend_cnt);
    end
    step();                       // N+2
    step();                       // N+3
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'hCAFE_0007;
    #1;
    checks++;
    if (busy_a !== 1'b0 || rd_data_a !== 32'hCAFE_0007) begin
      errors++;
      $display("FAIL wb_n3 busy=%b data=%h required busy=0 data=cafe0007", busy_a, rd_data_a);
    end
    checks++;
    if (pend_cnt !== 6'd1) begin
      errors++;
      $display("FAIL wb_n3_pend got %0d required 1", pend_cnt);
    end
    step();                       // N+4
    idle();
    #1;
    checks++;
    if (pend_cnt !== 6'd0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL wb_n4 pend=%0d busy=%b required pend=0 busy=0", pend_cnt, busy_a);
    end
  endtask

  task automatic test_set_wins();
    idle();
    iss_en = 1; iss_rd = 9; rd_addr_a = 9;
    step();
    iss_en = 1; iss_rd = 9;
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h9999_0001;
    #1;
    checks++;
    if (pend_cnt !== 6'd1) begin
      errors++;
      $display("FAIL set_wins_before pend got %0d required 1", pend_cnt);
    end
    step();
    idle();
    #1;
    checks++;
    if (busy_a !== 1'b1 || pend_cnt !== 6'd1) begin
      errors++;
      $display("FAIL set_wins busy=%b pend=%0d required busy=1 pend=1", busy_a, pend_cnt);
    end
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h9999_0002;
    step();
    idle();
  endtask

  task automatic test_reset_override();
    idle();
    iss_en = 1; iss_rd = 3;
    step();
    iss_rd = 4;
    step();
    idle();
    reset = 1;
    wr1_en = 1; wr1_addr = 3; wr1_data = 32'h3333_3333;
    iss_en = 1; iss_rd = 5;
    step();
    idle();
    for (int a = 3; a <= 5; a++) begin
      rd_addr_a = 5'(a);
      #1;
      checks++;
      if (busy_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_override_busy addr=%0d got %b required 0", a, busy_a);
      end
    end
    rd_addr_b = 3;
    #1;
    checks++;
    if (rd_data_b !== 32'h0 || pend_cnt !== 6'd0) begin
      errors++;
      $display("FAIL reset_override x3=%h pend=%0d required x3=0 pend=0", rd_data_b, pend_cnt);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset    = ($urandom_range(0, 63) == 0);
      wr0_en   = $urandom_range(0, 1) != 0;
      wr1_en   = $urandom_range(0, 2) == 0;
      iss_en   = $urandom_range(0, 1) != 0;
      // Small address range part of the time to force collisions.
      wr0_addr = 5'($urandom_range(0, (cyc % 2 != 0) ? 31 : 3));
      wr1_addr = 5'($urandom_range(0, (cyc % 2 != 0) ? 31 : 3));
      iss_rd   = 5'($urandom_range(0, (cyc % 2 != 0) ? 31 : 3));
      rd_addr_a = 5'($urandom_range(0, (cyc % 2 != 0) ? 31 : 3));
      rd_addr_b = 5'($urandom_range(0, 31));
      wr0_data = $urandom;
      wr1_data = $urandom;
      #1;
      checks++;
      if (rd_data_a !== exp_rd(rd_addr_a) || busy_a !== exp_busy(rd_addr_a)) begin
        errors++;
        $display("FAIL rand_a cyc=%0d addr=%0d data=%h busy=%b required data=%h busy=%b",
                 cyc, rd_addr_a, rd_data_a, busy_a, exp_rd(rd_addr_a), exp_busy(rd_addr_a));
      end
      checks++;
      if (rd_data_b !== exp_rd(rd_addr_b) || busy_b !== exp_busy(rd_addr_b)) begin
        errors++;
        $display("FAIL rand_b cyc=%0d addr=%0d data=%h busy=%b required data=%h busy=%b",
                 cyc, rd_addr_b, rd_data_b, busy_b, exp_rd(rd_addr_b), exp_busy(rd_addr_b));
      end
      checks++;
      if (pend_cnt !== exp_cnt()) begin
        errors++;
        $display("FAIL rand_pend_cnt cyc=%0d got %0d required %0d", cyc, pend_cnt, exp_cnt());
      end
      step();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 0;
      m_busy[i] = 0;
    end
    idle();
    rd_addr_a = 0; rd_addr_b = 0;
    @(negedge clk);
    test_reset();
    test_x0_x31();
    test_same_addr();
    test_issue_wb();
    test_set_wins();
    test_reset_override();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
